// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity frame checker family.
package parity_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Takes the reduction XOR of a word so the helper stays width-agnostic.
  function automatic logic expected_parity(input logic data_xor, input logic mode);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/parity_word_check.sv
// Combinational per-word parity check: expected parity and error flag for one word.
module parity_word_check
  import parity_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             par_i,
  input  logic             mode_i,
  output logic             exp_par_o,
  output logic             err_o
);

  assign exp_par_o = expected_parity(^data_i, mode_i);
  assign err_o     = (par_i != exp_par_o);

endmodule

// File: rtl/parity_frame_checker.sv
// Frame-level parity checker with report handshake and saturating error counter.
// Optional first-error index output is enabled by defining PARITY_FIRST_ERR_EN.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int FRAME_LEN = 4,
  parameter  int CNT_W     = 8,
  localparam int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             odd_mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_par_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             frame_par_o,
  output logic             frame_err_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [IDX_W-1:0] word_idx_o
`ifdef PARITY_FIRST_ERR_EN
  ,
  output logic [IDX_W-1:0] first_err_idx_o
`endif
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               mode_q, mode_d;
  logic               acc_xor_q, acc_xor_d;
  logic               acc_err_q, acc_err_d;
  logic               frame_par_q, frame_par_d;
  logic               frame_err_q, frame_err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic first_word, last_word, mode_eff, accept;
  logic word_exp, word_err, xor_new, err_new;

  assign first_word = (idx_q == '0);
  assign last_word  = (idx_q == IDX_W'(FRAME_LEN - 1));
  // The first word of a frame is checked against the live mode pin, later words
  // against the mode latched when that first word was taken.
  assign mode_eff   = first_word ? odd_mode_i : mode_q;
  assign accept     = in_valid_i && (state_q == ACCUM);
  assign xor_new    = (first_word ? 1'b0 : acc_xor_q) ^ (^in_data_i);
  assign err_new    = (first_word ? 1'b0 : acc_err_q) | word_err;

  parity_word_check #(.WIDTH(WIDTH)) u_word_check (
    .data_i    (in_data_i),
    .par_i     (in_par_i),
    .mode_i    (mode_eff),
    .exp_par_o (word_exp),
    .err_o     (word_err)
  );

`ifdef PARITY_FIRST_ERR_EN
  logic [IDX_W-1:0] fe_idx_q, fe_idx_d, fe_idx_new;
  logic             fe_seen_q, fe_seen_d, fe_seen_new;
  logic [IDX_W-1:0] first_err_idx_q, first_err_idx_d;

  always_comb begin
    fe_seen_new = first_word ? 1'b0 : fe_seen_q;
    fe_idx_new  = first_word ? '0 : fe_idx_q;
    if (word_err && !fe_seen_new) begin
      fe_seen_new = 1'b1;
      fe_idx_new  = idx_q;
    end
  end

  assign first_err_idx_o = first_err_idx_q;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    acc_xor_d   = acc_xor_q;
    acc_err_d   = acc_err_q;
    frame_par_d = frame_par_q;
    frame_err_d = frame_err_q;
    err_cnt_d   = err_cnt_q;
`ifdef PARITY_FIRST_ERR_EN
    fe_idx_d        = fe_idx_q;
    fe_seen_d       = fe_seen_q;
    first_err_idx_d = first_err_idx_q;
`endif
    case (state_q)
      ACCUM: begin
        if (accept) begin
          mode_d    = mode_eff;
          acc_xor_d = xor_new;
          acc_err_d = err_new;
          if (word_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
`ifdef PARITY_FIRST_ERR_EN
          fe_idx_d  = fe_idx_new;
          fe_seen_d = fe_seen_new;
`endif
          if (last_word) begin
            idx_d       = '0;
            state_d     = REPORT;
            frame_par_d = expected_parity(xor_new, mode_eff);
            frame_err_d = err_new;
`ifdef PARITY_FIRST_ERR_EN
            first_err_idx_d = fe_idx_new;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      REPORT: begin
        if (out_ready_i) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      idx_q       <= '0;
      mode_q      <= PARITY_EVEN;
      acc_xor_q   <= 1'b0;
      acc_err_q   <= 1'b0;
      frame_par_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
`ifdef PARITY_FIRST_ERR_EN
      fe_idx_q        <= '0;
      fe_seen_q       <= 1'b0;
      first_err_idx_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      acc_xor_q   <= acc_xor_d;
      acc_err_q   <= acc_err_d;
      frame_par_q <= frame_par_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
`ifdef PARITY_FIRST_ERR_EN
      fe_idx_q        <= fe_idx_d;
      fe_seen_q       <= fe_seen_d;
      first_err_idx_q <= first_err_idx_d;
`endif
    end
  end

  assign in_ready_o  = (state_q == ACCUM);
  assign out_valid_o = (state_q == REPORT);
  assign frame_par_o = frame_par_q;
  assign frame_err_o = frame_err_q;
  assign err_count_o = err_cnt_q;
  assign word_idx_o  = idx_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench for parity_frame_checker (WIDTH=8, FRAME_LEN=4, CNT_W=2 so saturation is reachable).
module tb_parity_frame_checker;

  localparam int WIDTH     = 8;
  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = 2;
  localparam int IDX_W     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             odd_mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_par;
  logic             out_valid;
  logic             out_ready;
  logic             frame_par;
  logic             frame_err;
  logic [CNT_W-1:0] err_count;
  logic [IDX_W-1:0] word_idx;
`ifdef PARITY_FIRST_ERR_EN
  logic [IDX_W-1:0] first_err_idx;
`endif

  typedef struct packed {
    logic             par;
    logic             err;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] fidx;
  } exp_t;

  exp_t expQ[$];
  exp_t mon;
  int   passCount  = 0;
  int   totalCount = 0;

  int               mdlIdx;
  logic             mdlMode, mdlXor, mdlErr, mdlSeen;
  logic [CNT_W-1:0] mdlCnt;
  logic [IDX_W-1:0] mdlFidx;

  parity_frame_checker #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .odd_mode_i  (odd_mode),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_par_i    (in_par),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .frame_par_o (frame_par),
    .frame_err_o (frame_err),
    .err_count_o (err_count),
    .word_idx_o  (word_idx)
`ifdef PARITY_FIRST_ERR_EN
    ,
    .first_err_idx_o (first_err_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    totalCount++;
    if (got === want) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask

  task automatic modelReset();
    mdlIdx  = 0;
    mdlMode = 1'b0;
    mdlXor  = 1'b0;
    mdlErr  = 1'b0;
    mdlSeen = 1'b0;
    mdlCnt  = '0;
    mdlFidx = '0;
  endtask

  // Asserts reset between clock edges and checks that outputs clear without waiting for a clock.
  task automatic doReset();
    #2 rst = 1'b1;
    #1;
    checkOutput("rstInReady",  32'(in_ready),  32'd1);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstFramePar", 32'(frame_par), 32'd0);
    checkOutput("rstFrameErr", 32'(frame_err), 32'd0);
    checkOutput("rstErrCount", 32'(err_count), 32'd0);
    checkOutput("rstWordIdx",  32'(word_idx),  32'd0);
`ifdef PARITY_FIRST_ERR_EN
    checkOutput("rstFirstErrIdx", 32'(first_err_idx), 32'd0);
`endif
    modelReset();
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic p, input logic m);
    int   waitCycles;
    logic wordMode, expP, werr;
    waitCycles = 0;
    odd_mode = m;
    in_data  = d;
    in_par   = p;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    wordMode = (mdlIdx == 0) ? m : mdlMode;
    if (mdlIdx == 0) begin
      mdlMode = m;
      mdlXor  = 1'b0;
      mdlErr  = 1'b0;
      mdlSeen = 1'b0;
      mdlFidx = '0;
    end
    expP   = wordMode ? ~^d : ^d;
    werr   = (p != expP);
    mdlXor = mdlXor ^ (^d);
    if (werr) begin
      mdlErr = 1'b1;
      if (!mdlSeen) begin
        mdlSeen = 1'b1;
        mdlFidx = IDX_W'(mdlIdx);
      end
      if (mdlCnt != 2'd3) mdlCnt = mdlCnt + 2'd1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (mdlIdx == FRAME_LEN - 1) begin
      expQ.push_back('{par: mdlMode ? ~mdlXor : mdlXor, err: mdlErr, cnt: mdlCnt,
                       fidx: mdlErr ? mdlFidx : '0});
      mdlIdx = 0;
      checkOutput("reportLatency", 32'(out_valid), 32'd1);
    end else begin
      mdlIdx++;
    end
    checkOutput("wordIdx", 32'(word_idx), 32'(mdlIdx));
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drainQueue", 32'(expQ.size()), 32'd0);
  endtask

  // Every report handshake pops the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedReport", 32'd1, 32'd0);
      end else begin
        mon = expQ.pop_front();
        checkOutput("framePar", 32'(frame_par), 32'(mon.par));
        checkOutput("frameErr", 32'(frame_err), 32'(mon.err));
        checkOutput("errCount", 32'(err_count), 32'(mon.cnt));
`ifdef PARITY_FIRST_ERR_EN
        checkOutput("firstErrIdx", 32'(first_err_idx), 32'(mon.fidx));
`endif
      end
    end
  end

  initial begin
    rst       = 1'b1;
    odd_mode  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_par    = 1'b0;
    out_ready = 1'b1;
    modelReset();
    #12;
    checkOutput("initInReady",  32'(in_ready),  32'd1);
    checkOutput("initOutValid", 32'(out_valid), 32'd0);
    checkOutput("initErrCount", 32'(err_count), 32'd0);
    checkOutput("initWordIdx",  32'(word_idx),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Even mode, clean frame.
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h03, 1'b0, 1'b0);
    applyStimulus(8'h07, 1'b1, 1'b0);
    applyStimulus(8'h0F, 1'b0, 1'b0);
    waitDrain();

    // Odd mode with a failing word.
    applyStimulus(8'hFF, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b1);
    applyStimulus(8'hAA, 1'b1, 1'b1);
    applyStimulus(8'h01, 1'b1, 1'b1);
    waitDrain();

    // Reset in the middle of a frame, then a fresh frame.
    applyStimulus(8'h01, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0);
    doReset();
    applyStimulus(8'h10, 1'b1, 1'b1);
    applyStimulus(8'h30, 1'b0, 1'b1);
    applyStimulus(8'h70, 1'b0, 1'b1);
    applyStimulus(8'hF0, 1'b1, 1'b1);
    waitDrain();

    // Backpressure with ignored input pulses.
    out_ready = 1'b0;
    applyStimulus(8'h5A, 1'b0, 1'b0);
    applyStimulus(8'h33, 1'b1, 1'b0);
    applyStimulus(8'h0C, 1'b0, 1'b0);
    applyStimulus(8'h81, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 8'hC3;
      in_par   = 1'b1;
      @(negedge clk);
      checkOutput("bpOutValid", 32'(out_valid), 32'd1);
      checkOutput("bpInReady",  32'(in_ready),  32'd0);
      checkOutput("bpWordIdx",  32'(word_idx),  32'd0);
      if (expQ.size() != 0) begin
        checkOutput("bpFramePar", 32'(frame_par), 32'(expQ[0].par));
        checkOutput("bpFrameErr", 32'(frame_err), 32'(expQ[0].err));
      end else begin
        checkOutput("bpQueueEmpty", 32'd0, 32'd1);
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitDrain();

    // Mode toggled after word 0 must not affect words 1-3.
    applyStimulus(8'h03, 1'b0, 1'b0);
    applyStimulus(8'h07, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h80, 1'b1, 1'b1);
    waitDrain();

    // Counter saturation: six bad words from a cleared counter.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(8'h01, 1'b0, 1'b0);
    checkOutput("satErrCount", 32'(err_count), 32'd3);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b0);
    waitDrain();

    // A few random frames.
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < FRAME_LEN; w++)
        applyStimulus(WIDTH'($urandom), 1'($urandom), 1'($urandom));
      waitDrain();
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
